// File: rtl/msp430_per_master_pkg.sv
// Shared types and helpers for the msp430 peripheral bus master.
package msp430_per_master_pkg;

   localparam int unsigned CMD_DEPTH_DEF = 2;
   localparam int unsigned ADDR_W        = 15;
   localparam int unsigned DATA_W        = 16;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_BSET  = 2'b10,
      OP_BCLR  = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      RD    = 3'd2,
      WR    = 3'd3,
      RSP   = 3'd4
   } state_e;

   typedef struct packed {
      cmd_op_e           op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              is_byte;
   } cmd_t;

   // Bit lanes touched by an access: whole word, or the addressed byte.
   function automatic logic [15:0] lane_mask(input logic is_byte, input logic a0);
      return !is_byte ? 16'hFFFF : (a0 ? 16'hFF00 : 16'h00FF);
   endfunction

   // Byte write enables for the write cycle.
   function automatic logic [1:0] we_mask(input logic is_byte, input logic a0);
      return !is_byte ? 2'b11 : (a0 ? 2'b10 : 2'b01);
   endfunction

   // Read data as returned on the response channel (bytes zero-extended).
   function automatic logic [15:0] rd_extract(input logic [15:0] dout, input logic is_byte,
                                              input logic a0);
      return !is_byte ? dout : (a0 ? {8'h00, dout[15:8]} : {8'h00, dout[7:0]});
   endfunction

endpackage

// File: rtl/msp430_per_cmd_fifo.sv
// Command FIFO with registered full/empty flags; DEPTH must be a power of two.
module msp430_per_cmd_fifo
   import msp430_per_master_pkg::*;
#(
   parameter int unsigned DEPTH = CMD_DEPTH_DEF
) (
   input  logic mclk,
   input  logic puc_rst,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic [AW:0]    count_nxt;
   logic           do_push;
   logic           do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + (AW+1)'(1);
      else if (do_pop && !do_push)
         count_nxt = count - (AW+1)'(1);
   end

   // Storage array, no reset needed.
   always_ff @(posedge mclk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // Pointers, occupancy and registered flags.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/msp430_per_master.sv
// Peripheral bus master: queued read/write/bit-set/bit-clear commands.
// MSP430_PER_MASTER_RMW_EN enables the read-modify-write bit-set/bit-clear path;
// without it those ops are answered with an error and no bus cycle.
module msp430_per_master
   import msp430_per_master_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = CMD_DEPTH_DEF
) (
   input  logic                mclk,
   input  logic                puc_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_data,
   input  logic                cmd_byte,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic [13:0]         per_addr,
   output logic [DATA_W-1:0]   per_din,
   output logic                per_en,
   output logic [1:0]          per_we,
   input  logic [DATA_W-1:0]   per_dout
);

   state_e state;
   cmd_t   fifo_din;
   cmd_t   fifo_dout;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_push;
   logic   fifo_pop;
   logic   cur_byte;
   logic   cur_a0;
`ifdef MSP430_PER_MASTER_RMW_EN
   cmd_op_e     cur_op;
   logic [15:0] cur_mask;
   logic [15:0] rmw_mask_c;
   logic [15:0] rmw_wdata_c;
`endif

   // Ready is withheld during reset and whenever the queue is full.
   assign cmd_ready = ~puc_rst & ~fifo_full;
   assign fifo_push = cmd_valid & cmd_ready;
   assign fifo_pop  = (state == SETUP);

   // Pack the incoming command.
   always_comb begin
      fifo_din         = '0;
      fifo_din.op      = cmd_op_e'(cmd_op);
      fifo_din.addr    = cmd_addr;
      fifo_din.data    = cmd_data;
      fifo_din.is_byte = cmd_byte;
   end

   msp430_per_cmd_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .din     (fifo_din),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef MSP430_PER_MASTER_RMW_EN
   // Modified word for bit-set/bit-clear; byte masks are confined to the addressed lane.
   always_comb begin
      rmw_mask_c  = cur_byte ? ({2{cur_mask[7:0]}} & lane_mask(cur_byte, cur_a0)) : cur_mask;
      rmw_wdata_c = (cur_op == OP_BSET) ? (per_dout | rmw_mask_c) : (per_dout & ~rmw_mask_c);
   end
`endif

   // Sequencer with registered bus and response outputs.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         per_addr  <= '0;
         per_din   <= '0;
         per_en    <= 1'b0;
         per_we    <= 2'b00;
         cur_byte  <= 1'b0;
         cur_a0    <= 1'b0;
`ifdef MSP430_PER_MASTER_RMW_EN
         cur_op    <= OP_READ;
         cur_mask  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A push this cycle lets SETUP start on the next one.
               if (!fifo_empty || fifo_push)
                  state <= SETUP;
            end
            SETUP: begin
               per_addr <= fifo_dout.addr[14:1];
               cur_byte <= fifo_dout.is_byte;
               cur_a0   <= fifo_dout.addr[0];
`ifdef MSP430_PER_MASTER_RMW_EN
               cur_op   <= fifo_dout.op;
               cur_mask <= fifo_dout.data;
`endif
               case (fifo_dout.op)
                  OP_READ: begin
                     per_en <= 1'b1;
                     per_we <= 2'b00;
                     state  <= RD;
                  end
                  OP_WRITE: begin
                     per_en  <= 1'b1;
                     per_we  <= we_mask(fifo_dout.is_byte, fifo_dout.addr[0]);
                     per_din <= fifo_dout.is_byte ? {2{fifo_dout.data[7:0]}} : fifo_dout.data;
                     state   <= WR;
                  end
                  default: begin
`ifdef MSP430_PER_MASTER_RMW_EN
                     per_en <= 1'b1;
                     per_we <= 2'b00;
                     state  <= RD;
`else
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     state     <= RSP;
`endif
                  end
               endcase
            end
            RD: begin
`ifdef MSP430_PER_MASTER_RMW_EN
               if (cur_op != OP_READ) begin
                  per_we  <= we_mask(cur_byte, cur_a0);
                  per_din <= rmw_wdata_c;
                  state   <= WR;
               end else
`endif
               begin
                  per_en    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= rd_extract(per_dout, cur_byte, cur_a0);
                  state     <= RSP;
               end
            end
            WR: begin
               per_en    <= 1'b0;
               per_we    <= 2'b00;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= per_din & lane_mask(cur_byte, cur_a0);
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= fifo_empty ? IDLE : SETUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/msp430_per_master.md
MSP430_PER_MASTER -- requirements
Module: msp430_per_master

Interface
REQ-001 The block SHALL have parameter CMD_DEPTH, default 2, command FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have port mclk  input  1  main system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port puc_rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-006 The block SHALL have port cmd_op  input  2  00 read, 01 write, 10 bit-set, 11 bit-clear.
REQ-007 The block SHALL have port cmd_addr  input  15  byte address.
REQ-008 The block SHALL have port cmd_data  input  16  write data or bit mask.
REQ-009 The block SHALL have port cmd_byte  input  1  byte access when 1, word access when 0.
REQ-010 The block SHALL have port rsp_valid  output  1  response available.
REQ-011 The block SHALL have port rsp_ready  input  1  response consumed.
REQ-012 The block SHALL have port rsp_data  output  16  read, or final written, value.
REQ-013 The block SHALL have port rsp_err  output  1  command rejected.
REQ-014 The block SHALL have port per_addr  output  14  peripheral word address, equal to cmd_addr[14:1].
REQ-015 The block SHALL have port per_din  output  16  peripheral write data.
REQ-016 The block SHALL have port per_en  output  1  peripheral access strobe.
REQ-017 The block SHALL have port per_we  output  2  peripheral byte write enables.
REQ-018 The block SHALL have port per_dout  input  16  peripheral read data, valid combinationally while per_en=1.

Function
REQ-019 A command SHALL be pushed when cmd_valid and cmd_ready are both 1.
REQ-020 cmd_ready SHALL be 0 whenever the FIFO is full, even in a cycle where the FIFO is popped.
REQ-021 Commands SHALL execute in order, and each SHALL produce exactly one response.
REQ-022 FSM states SHALL be IDLE, SETUP, RD, WR and RSP.
REQ-023 IDLE SHALL go to SETUP when the FIFO is non-empty; SETUP pops the head and loads the registered bus outputs.
REQ-024 SETUP SHALL go to RD for read, bit-set and bit-clear commands, and to WR for write commands.
REQ-025 RD and WR SHALL each last exactly one cycle with per_en=1; per_en SHALL be 0 in every other state.
REQ-026 In RD, per_we SHALL be 00; per_dout is captured at the end of the cycle.
REQ-027 After RD, a read command SHALL go to RSP and a bit-set or bit-clear command SHALL go to WR in the next cycle; per_en stays 1 across both cycles.
REQ-028 In WR, per_we SHALL be 11 for word access; for byte access it SHALL be 01 if cmd_addr[0]=0 and 10 if cmd_addr[0]=1.
REQ-029 For byte writes, per_din SHALL carry the data byte replicated in both halves.
REQ-030 Bit-set SHALL write captured|mask; bit-clear SHALL write captured&~mask; the mask is restricted to the addressed byte for byte access.
REQ-031 For byte reads, rsp_data SHALL be the addressed byte, zero-extended.
REQ-032 For writes, rsp_data SHALL be the value written, masked to the addressed byte for byte access.
REQ-033 In RSP, rsp_valid SHALL be 1 and SHALL hold until rsp_ready=1.
REQ-034 RSP SHALL go to SETUP if the FIFO is non-empty in that cycle, otherwise to IDLE.
REQ-035 Latency from acceptance at cycle N SHALL be: bus access at N+2, rsp_valid at N+3; bit-set/bit-clear read at N+2, write at N+3, rsp_valid at N+4.
REQ-036 rsp_data and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-037 The FIFO SHALL accept new commands while a bus access or response is in progress.

Reset
REQ-038 While puc_rst=1 at a clock edge, the following SHALL be 0: cmd_ready, rsp_valid, rsp_data, rsp_err, per_addr, per_din, per_en and per_we.
REQ-039 While puc_rst=1 at a clock edge, the FIFO SHALL be emptied and the FSM SHALL go to IDLE.
REQ-040 Reset mid-operation SHALL abort the command with no response, and no write SHALL complete after the reset edge.
REQ-041 cmd_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-042 Macro MSP430_PER_MASTER_RMW_EN defined: bit-set and bit-clear SHALL behave as in REQ-027 and REQ-030.
REQ-043 Macro MSP430_PER_MASTER_RMW_EN undefined: op 10/11 SHALL go SETUP->RSP with no bus cycle, rsp_err=1 and rsp_data=0; the RD->WR path SHALL not be synthesized.

Structure
REQ-044 Package msp430_per_master_pkg SHALL hold the op encoding enum, the FSM state enum, the command struct {op, addr, data, byte} and the CMD_DEPTH default.
REQ-045 The FIFO SHALL be a sub-module, msp430_per_cmd_fifo (parameterized depth, registered full/empty flags).

Verification
REQ-046 Word write addr 0x0192, data 0xA5C3 -> one cycle with per_en=1, per_addr=0x00C9, per_we=11, per_din=0xA5C3; then rsp_data=0xA5C3, rsp_err=0.
REQ-047 Byte read addr 0x0193 with per_dout=0x12AB -> per_we=00; rsp_data=0x0012 at N+3.
REQ-048 With the macro, bit-clear addr 0x0190 mask 0x00F0 and per_dout=0x0FFF -> read cycle, then write of per_din=0x0F0F; rsp_data=0x0F0F at N+4.
REQ-049 Without the macro, bit-set -> no per_en pulse, rsp_err=1, rsp_data=0.
REQ-050 Push 3 commands with rsp_ready=0 and CMD_DEPTH=2 -> cmd_ready deasserts; all 3 responses arrive in order once rsp_ready=1.
REQ-051 puc_rst asserted in the WR cycle -> per_en=0 on the next edge, no response, FIFO empty, cmd_ready=1 in the first cycle after release.
